// File: rtl/done_result_logger.sv
// Circular log of {IR, BUS} captured on each rising edge of the processor Done line.
// Build option: define LOGGER_OVERWRITE_EN to keep the newest entries when full instead of dropping.
module done_result_logger #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done,
  input  logic [DATA_W-1:0]     ir_in,
  input  logic [DATA_W-1:0]     bus_in,
  input  logic                  clear,
  input  logic                  rd_en,
  output logic [2*DATA_W-1:0]   rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_W:0]       count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [2*DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_done_q;
  logic [2*DATA_W-1:0] r_rd_data;
  logic                r_rd_valid;
  logic                r_overflow;

  logic w_cap;
  logic w_empty;
  logic w_full;
  logic w_rd;
  logic w_wr;
  logic w_lost;
  logic w_ovr_adv;
  logic w_mem_we;

  always_comb begin
    w_cap   = done & ~r_done_q;
    w_empty = (r_count == '0);
    w_full  = (r_count == FULL_COUNT);
    w_rd    = rd_en & ~w_empty;
    // A capture into a full buffer with no concurrent pop has nowhere to go.
    w_lost  = w_cap & w_full & ~w_rd;
`ifdef LOGGER_OVERWRITE_EN
    w_wr      = w_cap;
    w_ovr_adv = w_lost;
`else
    w_wr      = w_cap & (~w_full | w_rd);
    w_ovr_adv = 1'b0;
`endif
    w_mem_we = w_wr & ~rst & ~clear;
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr] <= {ir_in, bus_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (w_rd && !clear) begin
      r_rd_data <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_done_q   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done_q   <= done;
      r_rd_valid <= w_rd;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      // In overwrite mode the oldest entry is discarded by advancing the read side too.
      if (w_rd || w_ovr_adv) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      if (w_wr && !w_rd && !w_ovr_adv) begin
        r_count <= r_count + (ADDR_W+1)'(1);
      end else if (w_rd && !w_wr) begin
        r_count <= r_count - (ADDR_W+1)'(1);
      end
      if (w_lost) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_done_result_logger.sv
// Directed self-checking bench for done_result_logger; expectations follow LOGGER_OVERWRITE_EN when defined.
module tb_done_result_logger;

  localparam int DATA_W = 9;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

`ifdef LOGGER_OVERWRITE_EN
  localparam int BASE = 1;
`else
  localparam int BASE = 0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                done = 1'b0;
  logic [DATA_W-1:0]   ir_in = '0;
  logic [DATA_W-1:0]   bus_in = '0;
  logic                clear = 1'b0;
  logic                rd_en = 1'b0;
  logic [2*DATA_W-1:0] rd_data;
  logic                rd_valid;
  logic                empty;
  logic                full;
  logic [ADDR_W:0]     count;
  logic                overflow;

  int tests = 0;
  int fails = 0;

  done_result_logger #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .done(done), .ir_in(ir_in), .bus_in(bus_in),
    .clear(clear), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .full(full), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*DATA_W-1:0] entry(input int id);
    logic [DATA_W-1:0] b;
    b = DATA_W'(id);
    return {b ^ 9'h1AA, b};
  endfunction

  task automatic pulse(input int id);
    ir_in  = DATA_W'(id) ^ 9'h1AA;
    bus_in = DATA_W'(id);
    done   = 1'b1;
    tick();
    done   = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tests++; if (empty !== 1'b1)    begin fails++; $display("FAIL reset_empty got=%b exp=1", empty); end
    tests++; if (full !== 1'b0)     begin fails++; $display("FAIL reset_full got=%b exp=0", full); end
    tests++; if (count !== 6'd0)    begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL empty_read_valid got=%b exp=0", rd_valid); end
    tests++; if (rd_data !== 18'h0) begin fails++; $display("FAIL empty_read_data got=%h exp=00000", rd_data); end
    tests++; if (count !== 6'd0)    begin fails++; $display("FAIL empty_read_count got=%0d exp=0", count); end
    $display("[TB] reset/idle checked");
  endtask

  task automatic test_done_held();
    ir_in  = 9'h040;
    bus_in = 9'h005;
    done   = 1'b1;
    repeat (4) tick();
    done   = 1'b0;
    tick();
    tests++; if (count !== 6'd1) begin fails++; $display("FAIL held_count got=%0d exp=1", count); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tests++; if (rd_valid !== 1'b1)      begin fails++; $display("FAIL held_rd_valid got=%b exp=1", rd_valid); end
    tests++; if (rd_data !== 18'h08005)  begin fails++; $display("FAIL held_rd_data got=%h exp=08005", rd_data); end
    tests++; if (empty !== 1'b1)         begin fails++; $display("FAIL held_empty got=%b exp=1", empty); end
    tick();
    tests++; if (rd_valid !== 1'b0)      begin fails++; $display("FAIL held_valid_pulse got=%b exp=0", rd_valid); end
    $display("[TB] held done -> entry %h", rd_data);
  endtask

  task automatic test_fill_overflow();
    do_clear();
    for (int i = 0; i < DEPTH; i++) pulse(i);
    tests++; if (full !== 1'b1)     begin fails++; $display("FAIL fill_full got=%b exp=1", full); end
    tests++; if (count !== 6'd32)   begin fails++; $display("FAIL fill_count got=%0d exp=32", count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fill_overflow got=%b exp=0", overflow); end
    pulse(DEPTH);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    tests++; if (count !== 6'd32)   begin fails++; $display("FAIL ovf_count got=%0d exp=32", count); end
    for (int k = 0; k < DEPTH; k++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      tests++;
      if (rd_valid !== 1'b1 || rd_data !== entry(BASE + k)) begin
        fails++;
        $display("FAIL drain_%0d got=%b/%h exp=1/%h", k, rd_valid, rd_data, entry(BASE + k));
      end
    end
    tick();
    tests++; if (empty !== 1'b1)    begin fails++; $display("FAIL drain_empty got=%b exp=1", empty); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL drain_overflow_sticky got=%b exp=1", overflow); end
    $display("[TB] fill/overflow/drain done (first id %0d)", BASE);
  endtask

  task automatic test_back_to_back();
    int q[$];
    int exp_id;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      pulse(200 + i);
      q.push_back(200 + i);
    end
    for (int n = 0; n < 40; n++) begin
      ir_in  = DATA_W'(203 + n) ^ 9'h1AA;
      bus_in = DATA_W'(203 + n);
      done   = 1'b1;
      rd_en  = 1'b1;
      tick();
      done   = 1'b0;
      rd_en  = 1'b0;
      q.push_back(203 + n);
      exp_id = q.pop_front();
      tests++;
      if (rd_valid !== 1'b1 || rd_data !== entry(exp_id) || count !== 6'd3) begin
        fails++;
        $display("FAIL b2b_%0d got=%b/%h/%0d exp=1/%h/3", n, rd_valid, rd_data, count, entry(exp_id));
      end
      $display("[TB] b2b %0d pop %h count %0d", n, rd_data, count);
      tick();
    end
  endtask

  task automatic test_clear_priority();
    do_clear();
    for (int i = 0; i <= DEPTH; i++) pulse(i);
    for (int k = 0; k < DEPTH - 5; k++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    tick();
    tests++; if (count !== 6'd5 || overflow !== 1'b1) begin
      fails++; $display("FAIL clr_setup got=%0d/%b exp=5/1", count, overflow);
    end
    ir_in  = 9'h0AB;
    bus_in = 9'h0CD;
    clear  = 1'b1;
    done   = 1'b1;
    rd_en  = 1'b1;
    tick();
    clear  = 1'b0;
    done   = 1'b0;
    rd_en  = 1'b0;
    tests++; if (count !== 6'd0)    begin fails++; $display("FAIL clr_count got=%0d exp=0", count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL clr_overflow got=%b exp=0", overflow); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL clr_rd_valid got=%b exp=0", rd_valid); end
    tests++; if (rd_data !== entry(BASE + DEPTH - 6)) begin
      fails++; $display("FAIL clr_rd_data_hold got=%h exp=%h", rd_data, entry(BASE + DEPTH - 6));
    end
    tick();
    tests++; if (count !== 6'd0 || empty !== 1'b1) begin
      fails++; $display("FAIL clr_no_write got=%0d/%b exp=0/1", count, empty);
    end
    // Capture and pop together on an empty buffer: only the write happens.
    ir_in  = 9'h011;
    bus_in = 9'h022;
    done   = 1'b1;
    rd_en  = 1'b1;
    tick();
    done   = 1'b0;
    rd_en  = 1'b0;
    tests++; if (count !== 6'd1)    begin fails++; $display("FAIL emptyrw_count got=%0d exp=1", count); end
    tick();
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL emptyrw_valid got=%b exp=0", rd_valid); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tests++; if (rd_valid !== 1'b1 || rd_data !== {9'h011, 9'h022}) begin
      fails++; $display("FAIL emptyrw_data got=%b/%h exp=1/%h", rd_valid, rd_data, {9'h011, 9'h022});
    end
    $display("[TB] clear priority checked");
  endtask

  initial begin
    test_reset();
    test_done_held();
    test_fill_overflow();
    test_back_to_back();
    test_clear_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/done_result_logger.md
Name: done_result_logger

Overview:
- Write-side counterpart to the processor's ROM fetch path. The processor reads instructions from program memory; this block writes executed results into a log memory.
- On each instruction completion (rising edge of Done) it captures {IR, BUS} into a circular RAM buffer.
- A host or bench drains the buffer later through a registered read port.
- Sits beside the processor on the processor clock.

Parameters:
- DATA_W, 9, width of the IR and BUS words.
- ADDR_W, 5, log2 of buffer depth (DEPTH = 2**ADDR_W = 32 entries).

Ports:
- clk  input  1  processor clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- done  input  1  processor Done; level; may stay high for several cycles.
- ir_in  input  DATA_W  processor IR at completion.
- bus_in  input  DATA_W  processor BUS at completion.
- clear  input  1  synchronous flush of pointers and flags.
- rd_en  input  1  request to pop one entry.
- rd_data  output  2*DATA_W  popped entry {ir, bus}, registered.
- rd_valid  output  1  one-cycle pulse marking rd_data valid.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  ADDR_W+1  entries held, 0..DEPTH.
- overflow  output  1  sticky: a capture was lost (or, with the option enabled, an entry was overwritten).

Behaviour:
- Reset (rst=1 at clk edge): wr_ptr=0, rd_ptr=0, count=0, done_q=0, rd_data=0, rd_valid=0, overflow=0. Hence empty=1, full=0. Memory contents are not cleared.
- Edge detect: done_q <= done every cycle. Capture event cap = done & ~done_q, so Done held N cycles yields exactly one entry. Done high during the first cycle after reset or clear counts as a rising edge.
- Write: on cap with ~full, mem[wr_ptr] <= {ir_in, bus_in} sampled in that same cycle; wr_ptr increments modulo DEPTH. Write latency is 0 cycles; the entry becomes readable the next cycle.
- Read: on rd_en with ~empty, rd_data <= mem[rd_ptr] and rd_ptr increments modulo DEPTH. rd_valid=1 the next cycle only. Read latency is 1 cycle.
- rd_en while empty: ignored. rd_valid=0, rd_data holds its previous value.
- Pointers wrap from DEPTH-1 to 0. full and empty derive from count, not from pointer compare.
- count: +1 on write only, -1 on read only, unchanged on simultaneous write and read or on neither.
- Simultaneous cap and rd_en:
  - empty: write only. The read is not bypassed; rd_valid=0.
  - full: both occur. The read frees the slot, count stays DEPTH, overflow is not set.
  - otherwise: both occur, count unchanged.
- cap while full without a simultaneous read: entry dropped, overflow <= 1.
- overflow clears only on rst or clear.
- clear: takes priority over cap and rd_en in the same cycle. Behaves as reset for pointers, count, done_q, rd_valid and overflow. rd_data holds.
- rst or clear mid-operation discards everything pending. No partial entries exist, since each write is single-cycle.

Optional Feature:
- Macro: LOGGER_OVERWRITE_EN.
- Defined: cap while full and no read writes mem[wr_ptr], advances wr_ptr and rd_ptr together, keeps count=DEPTH and sets overflow. The oldest entry is lost and the buffer always holds the newest DEPTH results.
- Undefined: drop-new behaviour as above.

Test Plan:
- Reset then idle: empty=1, full=0, count=0, overflow=0, rd_valid=0. rd_en pulse gives rd_valid=0.
- done held high 4 cycles with ir_in=9'h040, bus_in=9'h005 -> count=1. rd_en next cycle -> following cycle rd_valid=1, rd_data=18'h08005, empty=1.
- 32 done pulses with bus_in=0..31 -> full=1, count=32. 33rd pulse -> overflow=1, count=32. Draining yields 0..31 in order.
- Same as above with LOGGER_OVERWRITE_EN -> after the 33rd pulse (bus=32), drain yields 1..32, overflow=1.
- Steady state with count=3: cap and rd_en in the same cycle -> count stays 3, oldest entry popped, new entry appended. Repeat 40 times to exercise pointer wrap with no data corruption.
- Buffer holding 5 entries and overflow=1: assert clear together with cap and rd_en -> count=0, overflow=0, rd_valid=0 next cycle, no entry written.
